// File: rtl/udp_payload_reader.sv
// Reads a UDP segment back from the parser's payload RAM, decodes the header,
// optionally filters on destination port and streams payload bytes MSB-first.
module udp_payload_reader #(
    parameter int          FIRST_ADDR  = 1,
    parameter int          RD_LAT      = 2,
    parameter int          FILTER_EN   = 0,
    parameter logic [15:0] LISTEN_PORT = 16'd5000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start_read,
    input  logic [9:0]  last_addr,
    output logic [9:0]  rd_addr,
    input  logic [31:0] rd_data,
    output logic [7:0]  m_data,
    output logic        m_valid,
    input  logic        m_ready,
    output logic        m_last,
    output logic [15:0] src_port,
    output logic [15:0] dst_port,
    output logic [15:0] udp_len,
    output logic        hdr_valid,
    output logic        busy,
    output logic        done,
    output logic        err_len,
    output logic        dropped
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR0, S_HDR1, S_CHECK, S_FETCH, S_EMIT
    } state_t;

    localparam int             CW    = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);
    localparam logic [CW-1:0]  LAT   = CW'(RD_LAT);
    localparam logic [9:0]     FIRST = 10'(FIRST_ADDR);

    state_t        state, state_next;
    logic [9:0]    last_q;
    logic [CW-1:0] wait_cnt;
    logic [31:0]   shift_buf;
    logic [15:0]   bytes_left;
    logic [1:0]    byte_idx;
    logic          done_next, err_set, drop_set;

    function automatic logic [10:0] word_count(input logic [9:0] addr);
        if (addr < FIRST)
            return 11'd0;
        return {1'b0, addr} - {1'b0, FIRST} + 11'd1;
    endfunction

    logic [10:0] nwords_in, nwords_q;
    logic [15:0] payload_len, avail_bytes, check_len;
    logic        fetching, word_ready, accept;

    assign nwords_in   = word_count(last_addr);
    assign nwords_q    = word_count(last_q);
    assign payload_len = udp_len - 16'd8;
    // Only meaningful once the header was read, i.e. nwords_q >= 2.
    assign avail_bytes = {3'b000, nwords_q - 11'd2, 2'b00};
    assign check_len   = (payload_len > avail_bytes) ? avail_bytes : payload_len;

    assign fetching   = (state == S_HDR0) || (state == S_HDR1) || (state == S_FETCH);
    assign word_ready = (wait_cnt == LAT);
    assign accept     = m_valid && m_ready;

    assign m_valid = (state == S_EMIT);
    assign m_data  = shift_buf[31:24];
    assign m_last  = m_valid && (bytes_left == 16'd1);
    assign busy    = (state != S_IDLE);

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_next = state;
        done_next  = 1'b0;
        err_set    = 1'b0;
        drop_set   = 1'b0;
        case (state)
            S_IDLE: begin
                if (start_read) begin
                    if (nwords_in < 11'd2) begin
                        err_set   = 1'b1;
                        done_next = 1'b1;
                    end else begin
                        state_next = S_HDR0;
                    end
                end
            end
            S_HDR0:  if (word_ready) state_next = S_HDR1;
            S_HDR1:  if (word_ready) state_next = S_CHECK;
            S_CHECK: begin
                state_next = S_IDLE;
                if (udp_len < 16'd8) begin
                    err_set   = 1'b1;
                    done_next = 1'b1;
                end else if (FILTER_EN != 0 && dst_port != LISTEN_PORT) begin
                    drop_set  = 1'b1;
                    done_next = 1'b1;
                end else begin
                    err_set = (payload_len > avail_bytes);
                    if (check_len == 16'd0) done_next  = 1'b1;
                    else                    state_next = S_FETCH;
                end
            end
            S_FETCH: if (word_ready) state_next = S_EMIT;
            S_EMIT: begin
                if (accept) begin
                    if (bytes_left == 16'd1) begin
                        done_next  = 1'b1;
                        state_next = S_IDLE;
                    end else if (byte_idx == 2'd3) begin
                        state_next = S_FETCH;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr    <= '0;
            last_q     <= '0;
            wait_cnt   <= '0;
            shift_buf  <= '0;
            bytes_left <= '0;
            byte_idx   <= '0;
            src_port   <= '0;
            dst_port   <= '0;
            udp_len    <= '0;
            hdr_valid  <= 1'b0;
            done       <= 1'b0;
            err_len    <= 1'b0;
            dropped    <= 1'b0;
        end else begin
            done     <= done_next;
            wait_cnt <= (fetching && !word_ready) ? wait_cnt + 1'b1 : '0;
            case (state)
                S_IDLE: begin
                    if (start_read) begin
                        last_q    <= last_addr;
                        hdr_valid <= 1'b0;
                        err_len   <= 1'b0;
                        dropped   <= 1'b0;
                        if (nwords_in >= 11'd2) rd_addr <= FIRST;
                    end
                end
                S_HDR0: begin
                    if (word_ready) begin
                        src_port <= rd_data[31:16];
                        dst_port <= rd_data[15:0];
                        rd_addr  <= rd_addr + 10'd1;
                    end
                end
                S_HDR1: begin
                    if (word_ready) begin
                        udp_len   <= rd_data[31:16];
                        hdr_valid <= 1'b1;
                    end
                end
                S_CHECK: begin
                    bytes_left <= check_len;
                    if (state_next == S_FETCH) rd_addr <= rd_addr + 10'd1;
                end
                S_FETCH: begin
                    if (word_ready) begin
                        shift_buf <= rd_data;
                        byte_idx  <= 2'd0;
                    end
                end
                S_EMIT: begin
                    if (accept) begin
                        shift_buf  <= {shift_buf[23:0], 8'h00};
                        bytes_left <= bytes_left - 16'd1;
                        byte_idx   <= byte_idx + 2'd1;
                        if (state_next == S_FETCH) rd_addr <= rd_addr + 10'd1;
                    end
                end
                default: ;
            endcase
            // Error/drop flags set this cycle override the clear on start_read.
            if (err_set)  err_len <= 1'b1;
            if (drop_set) dropped <= 1'b1;
        end
    end

endmodule

// File: tb/tb_udp_payload_reader.sv
// Directed bench for udp_payload_reader: RAM model with 2-cycle read latency,
// hand-computed expected headers, byte streams, flags and latencies.
module tb_udp_payload_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_read;
    logic [9:0]  last_addr;
    logic [9:0]  rd_addr;
    logic [31:0] rd_data;
    logic [7:0]  m_data;
    logic        m_valid, m_ready, m_last;
    logic [15:0] src_port, dst_port, udp_len;
    logic        hdr_valid, busy, done, err_len, dropped;

    always #5 clk = ~clk;

    udp_payload_reader #(
        .FIRST_ADDR (1),
        .RD_LAT     (2),
        .FILTER_EN  (1),
        .LISTEN_PORT(16'd5000)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start_read(start_read),
        .last_addr (last_addr),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_last    (m_last),
        .src_port  (src_port),
        .dst_port  (dst_port),
        .udp_len   (udp_len),
        .hdr_valid (hdr_valid),
        .busy      (busy),
        .done      (done),
        .err_len   (err_len),
        .dropped   (dropped)
    );

    // Registered address + synchronous RAM: data valid two edges after rd_addr.
    logic [31:0] mem [0:1023];
    logic [9:0]  addr_q;
    always @(posedge clk) begin
        addr_q  <= rd_addr;
        rd_data <= mem[addr_q];
    end

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] got_q[$];
    logic       got_last[$];
    int         n_done, n_valid, n_stall, lat;
    logic [9:0] max_addr;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_stream(input string tag, input logic [63:0] exp, input int n);
        check({tag, "_nbytes"}, 64'(got_q.size()), 64'(n));
        for (int i = 0; i < n; i++) begin
            if (i < got_q.size()) begin
                check($sformatf("%s_byte%0d", tag, i), 64'(got_q[i]), 64'(exp[63-8*i -: 8]));
                check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), 64'(i == n - 1));
            end
        end
    endtask

    // mode 0: m_ready held high; mode 1: m_ready follows 1-0-0-1.
    // inject_at != 0: pulse a spurious start_read at that cycle.
    task automatic run_seg(input string tag, input logic [9:0] last, input int mode,
                           input int inject_at);
        logic [3:0] pat;
        logic       seen, prev_stall;
        logic [7:0] prev_data;
        int         cyc;
        pat = 4'b1001;
        got_q.delete();
        got_last.delete();
        n_done = 0; n_valid = 0; n_stall = 0; lat = 0; max_addr = '0;
        seen = 1'b0; prev_stall = 1'b0; prev_data = '0; cyc = 0;
        @(negedge clk);
        last_addr  = last;
        start_read = 1'b1;
        m_ready    = 1'b1;
        while (cyc < 400 && (!seen || cyc < lat + 4)) begin
            @(negedge clk);
            cyc++;
            start_read = (inject_at != 0 && cyc == inject_at);
            if (start_read) last_addr = 10'd2;
            m_ready = (mode == 0) ? 1'b1 : pat[cyc % 4];
            if (done) begin
                n_done++;
                if (!seen) lat = cyc;
                seen = 1'b1;
            end
            if (m_valid) n_valid++;
            if (prev_stall && (!m_valid || m_data != prev_data)) n_stall++;
            if (m_valid && m_ready) begin
                got_q.push_back(m_data);
                got_last.push_back(m_last);
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            if (busy && rd_addr > max_addr) max_addr = rd_addr;
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        m_ready = 1'b1;
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
        rst = 1'b1; start_read = 1'b0; last_addr = '0; m_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_busy",    64'(busy),    64'd0);
        check("rst_done",    64'(done),    64'd0);
        check("rst_rd_addr", 64'(rd_addr), 64'd0);
        check("rst_hdr",     64'(hdr_valid), 64'd0);
        check("rst_m_data",  64'(m_data),  64'd0);
        rst = 1'b0;

        // T1: basic 4-byte payload
        mem[1] = 32'h1F901388; mem[2] = 32'h000C0000; mem[3] = 32'hDEADBEEF;
        mem[4] = 32'h11223344;
        run_seg("t1", 10'd3, 0, 0);
        check("t1_src",      64'(src_port), 64'd8080);
        check("t1_dst",      64'(dst_port), 64'd5000);
        check("t1_len",      64'(udp_len),  64'd12);
        check_stream("t1", {32'hDEADBEEF, 32'h0}, 4);
        check("t1_ndone",    64'(n_done),   64'd1);
        check("t1_lat",      64'(lat),      64'd15);
        check("t1_err",      64'(err_len),  64'd0);
        check("t1_drop",     64'(dropped),  64'd0);
        check("t1_hdr",      64'(hdr_valid), 64'd1);
        check("t1_busy",     64'(busy),     64'd0);
        check("t1_max_addr", 64'(max_addr), 64'd3);
        check("t1_nvalid",   64'(n_valid),  64'd4);

        // T2: udp_len=10 -> only 2 payload bytes
        mem[2] = 32'h000A0000;
        run_seg("t2", 10'd3, 0, 0);
        check_stream("t2", {16'hDEAD, 48'h0}, 2);
        check("t2_nvalid", 64'(n_valid), 64'd2);
        check("t2_err",    64'(err_len), 64'd0);
        check("t2_ndone",  64'(n_done),  64'd1);

        // T3: udp_len=20 but only one data word -> truncated
        mem[2] = 32'h00140000;
        run_seg("t3", 10'd3, 0, 0);
        check_stream("t3", {32'hDEADBEEF, 32'h0}, 4);
        check("t3_err", 64'(err_len), 64'd1);
        check("t3_len", 64'(udp_len), 64'd20);

        // T4: udp_len=6 < header size
        mem[2] = 32'h00060000;
        run_seg("t4", 10'd3, 0, 0);
        check("t4_nvalid", 64'(n_valid),   64'd0);
        check("t4_err",    64'(err_len),   64'd1);
        check("t4_hdr",    64'(hdr_valid), 64'd1);
        check("t4_ndone",  64'(n_done),    64'd1);

        // T5: wrong destination port is dropped
        mem[1] = 32'h1F901389; mem[2] = 32'h000C0000;
        run_seg("t5", 10'd3, 0, 0);
        check("t5_drop",   64'(dropped),   64'd1);
        check("t5_nvalid", 64'(n_valid),   64'd0);
        check("t5_ndone",  64'(n_done),    64'd1);
        check("t5_err",    64'(err_len),   64'd0);
        check("t5_hdr",    64'(hdr_valid), 64'd1);

        // T6: matching port passes and clears dropped
        mem[1] = 32'h1F901388;
        run_seg("t6", 10'd3, 0, 0);
        check("t6_drop", 64'(dropped), 64'd0);
        check_stream("t6", {32'hDEADBEEF, 32'h0}, 4);

        // T7: two data words, stalling sink, spurious start_read mid-stream
        mem[2] = 32'h00100000; mem[4] = 32'h01234567; mem[5] = 32'h55555555;
        run_seg("t7", 10'd4, 1, 12);
        check_stream("t7", 64'hDEADBEEF01234567, 8);
        check("t7_stall",    64'(n_stall),  64'd0);
        check("t7_ndone",    64'(n_done),   64'd1);
        check("t7_max_addr", 64'(max_addr), 64'd4);
        check("t7_err",      64'(err_len),  64'd0);

        // T8: reset while byte 2 is presented, then a fresh segment
        mem[2] = 32'h000C0000;
        begin
            int cyc;
            int pre_bytes;
            int late_done;
            cyc = 0; pre_bytes = 0; late_done = 0;
            @(negedge clk);
            last_addr = 10'd3; start_read = 1'b1; m_ready = 1'b1;
            while (cyc < 13) begin
                @(negedge clk);
                cyc++;
                start_read = 1'b0;
                if (m_valid && m_ready && cyc < 13) pre_bytes++;
                if (done) late_done++;
            end
            check("t8_pre_bytes", 64'(pre_bytes), 64'd2);
            check("t8_byte2",     64'(m_data),    64'hBE);
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            check("t8_m_valid", 64'(m_valid),   64'd0);
            check("t8_busy",    64'(busy),      64'd0);
            check("t8_rd_addr", 64'(rd_addr),   64'd0);
            check("t8_hdr",     64'(hdr_valid), 64'd0);
            check("t8_src",     64'(src_port),  64'd0);
            check("t8_m_data",  64'(m_data),    64'd0);
            repeat (5) begin
                @(negedge clk);
                if (done) late_done++;
            end
            check("t8_no_done", 64'(late_done), 64'd0);
        end
        mem[3] = 32'hCAFEF00D;
        run_seg("t8b", 10'd3, 0, 0);
        check_stream("t8b", {32'hCAFEF00D, 32'h0}, 4);
        check("t8b_lat", 64'(lat), 64'd15);
        check("t8b_err", 64'(err_len), 64'd0);

        // T9: fewer than two words available
        run_seg("t9", 10'd1, 0, 0);
        check("t9_err",    64'(err_len),   64'd1);
        check("t9_hdr",    64'(hdr_valid), 64'd0);
        check("t9_nvalid", 64'(n_valid),   64'd0);
        check("t9_lat",    64'(lat),       64'd1);

        // T10: last_addr below FIRST_ADDR
        run_seg("t10", 10'd0, 0, 0);
        check("t10_err",    64'(err_len), 64'd1);
        check("t10_nvalid", 64'(n_valid), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
